mrv1_ifq: RTL and testbench
===========================

# mrv1_ifq

Parametrised multi-thread instruction fetch queue with compressed-instruction (RVC) alignment and ready/valid handshakes on both sides. It sits between the I-cache fetch return path and the decode stage. It buffers 32-bit aligned fetch words tagged with PC and thread ID, and presents one 16- or 32-bit instruction per cycle. A 32-bit instruction may straddle two consecutive queue entries. The block supports any depth, a synchronous flush, and occupancy reporting.

## Interface
- PC_WIDTH_P, 32, PC width
- NUM_THREADS_P, 8, hardware thread count
- DEPTH_P, 4, entries; any value ≥2, not restricted to powers of two
- TID_WIDTH_LP, $clog2(NUM_THREADS_P), thread ID width
- PTR_WIDTH_LP, $clog2(DEPTH_P), pointer width
- CNT_WIDTH_LP, $clog2(DEPTH_P+1), occupancy width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- flush_i  in  1  synchronous flush, highest priority
- in_vld_i  in  1  fetch word valid
- in_rdy_o  out  1  queue can accept a word
- in_data_i  in  32  fetch word; parcel0 = [15:0], parcel1 = [31:16]
- in_pc_i  in  PC_WIDTH_P  fetch PC; bit 1 set means parcel0 is not part of the stream
- in_tid_i  in  TID_WIDTH_LP  thread ID
- out_vld_o  out  1  aligned instruction available
- out_rdy_i  in  1  decode accepts
- out_insn_o  out  32  instruction; RVC is zero-extended
- out_pc_o  out  PC_WIDTH_P  instruction PC
- out_tid_o  out  TID_WIDTH_LP  thread of the instruction
- out_rvc_o  out  1  instruction is 16-bit
- out_fault_o  out  1  32-bit instruction truncated by a discontinuity
- count_o  out  CNT_WIDTH_LP  occupied entries
- empty_o / full_o  out  1  count_o==0 / count_o==DEPTH_P

## Operation
- Circular buffer. Pointers wrap from DEPTH_P-1 to 0 by explicit compare, not modulo-2^n. Each entry holds data, pc, tid and vld. Storage resets to 0.
- Enqueue when in_vld_i && in_rdy_o. in_rdy_o = !full_o. A same-cycle pop does not raise in_rdy_o.
- Half offset h selects the current parcel p of the head entry. When an entry becomes head, h = entry.pc[1], except after a spanning pop (see below).
- RVC test: p[1:0] != 2'b11.
- RVC instruction: out_insn_o = {16'h0, p}, out_rvc_o = 1. out_vld_o = head valid.
- 32-bit with h=0: out_insn_o = head.data. out_vld_o = head valid.
- 32-bit with h=1 (spanning): out_insn_o = {next.data[15:0], head.data[31:16]}. out_vld_o requires the next entry to be valid.
  - Contiguous case: next.tid == head.tid and next.pc[PC-1:2] == head.pc[PC-1:2]+1.
  - Otherwise out_fault_o = 1, and the instruction is still presented as valid.
- out_pc_o = {head.pc[PC-1:2], h, 1'b0}. out_tid_o = head.tid.
- Pop on out_vld_o && out_rdy_i:
  - RVC, h=0: h←1, no entry freed.
  - RVC, h=1: free head.
  - 32-bit, h=0: free head.
  - 32-bit spanning, contiguous: free head; the new head starts at h=1.
  - Faulted: free head; the new head starts at its own pc[1].
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- flush_i clears count, pointers, h and all vld bits. A same-cycle enqueue or pop is ignored.
- Mid-operation reset: all state returns to reset values immediately; no handshake completes.

## Timing
- Reset values: in_rdy_o=1, out_vld_o=0, out_fault_o=0, out_rvc_o=0, out_insn_o/out_pc_o/out_tid_o=0, count_o=0, empty_o=1, full_o=0.
- Enqueue-to-output latency is 1 cycle: a word accepted in cycle N is presentable in cycle N+1.
- A spanning instruction becomes valid 1 cycle after its second word is accepted.
- Output fields are combinational from registered state only. There is no combinational path from in_* or out_rdy_i to any output.
- Throughput: 1 instruction per cycle. A word of two RVC instructions needs 2 cycles to drain.
- After a flush asserted in cycle N, the queue is empty and in_rdy_o=1 in cycle N+1.

## Structure
- Package mrv1_ifq_pkg:
  - typedef of the entry struct (data, pc, tid), parameterised through the module's localparams;
  - PARCEL_W=16;
  - function is_rvc(parcel).
- Sub-module mrv1_ifq_align: purely combinational. It takes head and next entries plus h, and returns insn, rvc, vld, fault and pc.
- The queue top holds storage, pointers, count and h.

## Test plan
- Reset, then enqueue 32'h0000_0013 at pc 0x100, tid 2 → next cycle out_vld_o=1, insn 0x00000013, out_pc_o 0x100, rvc=0. Pop → empty_o=1.
- Enqueue 32'h4501_4505 at pc 0x200 → two pops: insn 0x4505 at pc 0x200, then 0x4501 at pc 0x202, both rvc=1, count_o decrements only after the second pop.
- Enqueue word 0x0013_4505 at 0x300, then 0x1234_0000 at 0x304, same tid → RVC at 0x300, then 32-bit insn 0x0000_0013 at 0x302; the next head starts at pc 0x306.
- Same as above, but the second word has a different tid → out_fault_o=1 at 0x302; the next head presents at its own pc[1].
- With DEPTH_P=3, fill to full → in_rdy_o=0 and in_vld_i is ignored. Pop and enqueue back-to-back for 10 cycles → pointers wrap 2→0 with no loss and in-order PCs.
- Fill 2 entries, assert flush_i together with in_vld_i → next cycle count_o=0, out_vld_o=0. Assert rst_ni=0 mid-stream → outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/mrv1_ifq_pkg.sv
// Shared types and helpers for the mrv1 instruction fetch queue.
// Entry fields are sized for the widest supported PC/TID; modules use the low bits.
package mrv1_ifq_pkg;

  localparam int PARCEL_W      = 16;
  localparam int INSN_W        = 32;
  localparam int IFQ_PC_MAX_W  = 64;
  localparam int IFQ_TID_MAX_W = 16;

  typedef struct packed {
    logic                     vld;
    logic [INSN_W-1:0]        data;
    logic [IFQ_PC_MAX_W-1:0]  pc;
    logic [IFQ_TID_MAX_W-1:0] tid;
  } ifq_entry_t;

  function automatic logic is_rvc(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/mrv1_ifq_align.sv
// Combinational RVC aligner: picks the current parcel of the head entry and,
// for a 32-bit instruction starting in the upper half, borrows the next entry.
module mrv1_ifq_align
  import mrv1_ifq_pkg::*;
#(
  parameter int PC_WIDTH_P  = 32,
  parameter int TID_WIDTH_P = 3
) (
  input  ifq_entry_t              head_ent,
  input  ifq_entry_t              next_ent,
  input  logic                    half,
  output logic [INSN_W-1:0]       insn,
  output logic                    rvc,
  output logic                    vld,
  output logic                    fault,
  output logic [PC_WIDTH_P-1:0]   pc,
  output logic [TID_WIDTH_P-1:0]  tid
);

  logic [PARCEL_W-1:0]     parcel;
  logic                    rvc_raw;
  logic                    span;
  logic                    contig;
  logic [PC_WIDTH_P-3:0]   head_line;
  logic [PC_WIDTH_P-3:0]   next_line;
  logic [2*$bits(ifq_entry_t)-1:0] unused_ent;

  // Only the low PC/TID bits carry meaning for this instance.
  assign unused_ent = {head_ent, next_ent};

  assign head_line = head_ent.pc[PC_WIDTH_P-1:2];
  assign next_line = next_ent.pc[PC_WIDTH_P-1:2];
  assign parcel    = half ? head_ent.data[31:16] : head_ent.data[15:0];
  assign rvc_raw   = is_rvc(parcel);
  assign span      = !rvc_raw && half;
  assign contig    = (next_ent.tid[TID_WIDTH_P-1:0] == head_ent.tid[TID_WIDTH_P-1:0]) &&
                     (next_line == head_line + (PC_WIDTH_P-2)'(1));

  always_comb begin
    vld   = head_ent.vld && (!span || next_ent.vld);
    insn  = '0;
    rvc   = 1'b0;
    fault = 1'b0;
    pc    = '0;
    tid   = '0;
    if (vld) begin
      rvc   = rvc_raw;
      fault = span && !contig;
      pc    = {head_line, half, 1'b0};
      tid   = head_ent.tid[TID_WIDTH_P-1:0];
      if (rvc_raw)   insn = {16'h0, parcel};
      else if (span) insn = {next_ent.data[15:0], head_ent.data[31:16]};
      else           insn = head_ent.data;
    end
  end

endmodule

// File: rtl/mrv1_ifq.sv
// Multi-thread instruction fetch queue: circular buffer of fetch words with
// an RVC aligner on the head, ready/valid on both sides and synchronous flush.
module mrv1_ifq
  import mrv1_ifq_pkg::*;
#(
  parameter  int PC_WIDTH_P    = 32,
  parameter  int NUM_THREADS_P = 8,
  parameter  int DEPTH_P       = 4,
  localparam int TID_WIDTH_LP  = $clog2(NUM_THREADS_P),
  localparam int PTR_WIDTH_LP  = $clog2(DEPTH_P),
  localparam int CNT_WIDTH_LP  = $clog2(DEPTH_P + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    in_vld_i,
  output logic                    in_rdy_o,
  input  logic [31:0]             in_data_i,
  input  logic [PC_WIDTH_P-1:0]   in_pc_i,
  input  logic [TID_WIDTH_LP-1:0] in_tid_i,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i,
  output logic [31:0]             out_insn_o,
  output logic [PC_WIDTH_P-1:0]   out_pc_o,
  output logic [TID_WIDTH_LP-1:0] out_tid_o,
  output logic                    out_rvc_o,
  output logic                    out_fault_o,
  output logic [CNT_WIDTH_LP-1:0] count_o,
  output logic                    empty_o,
  output logic                    full_o
);

  ifq_entry_t              mem_reg [DEPTH_P];
  logic [PTR_WIDTH_LP-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
  logic [CNT_WIDTH_LP-1:0] count_reg;
  // Set when the head's lower parcel has already been consumed.
  logic                    half_set_reg, half_set_next;
  logic                    half;
  logic                    push, pop, free;
  ifq_entry_t              head_ent, next_ent, wr_ent;

  function automatic logic [PTR_WIDTH_LP-1:0] ptr_inc(input logic [PTR_WIDTH_LP-1:0] p);
    return (p == PTR_WIDTH_LP'(DEPTH_P - 1)) ? '0 : p + PTR_WIDTH_LP'(1);
  endfunction

  assign rd_ptr_inc = ptr_inc(rd_ptr_reg);
  assign head_ent   = mem_reg[rd_ptr_reg];
  assign next_ent   = mem_reg[rd_ptr_inc];
  assign half       = half_set_reg | head_ent.pc[1];

  assign full_o   = (count_reg == CNT_WIDTH_LP'(DEPTH_P));
  assign empty_o  = (count_reg == '0);
  assign count_o  = count_reg;
  assign in_rdy_o = !full_o;

  assign push = in_vld_i && in_rdy_o;
  assign pop  = out_vld_o && out_rdy_i;
  // Only an RVC taken from the lower half leaves the head in place.
  assign free = pop && (half || !out_rvc_o);

  always_comb begin
    wr_ent      = '0;
    wr_ent.vld  = 1'b1;
    wr_ent.data = in_data_i;
    wr_ent.pc   = IFQ_PC_MAX_W'(in_pc_i);
    wr_ent.tid  = IFQ_TID_MAX_W'(in_tid_i);
  end

  always_comb begin
    half_set_next = half_set_reg;
    if (pop) begin
      half_set_next = (out_rvc_o && !half) || (!out_rvc_o && half && !out_fault_o);
    end
  end

  mrv1_ifq_align #(
    .PC_WIDTH_P  (PC_WIDTH_P),
    .TID_WIDTH_P (TID_WIDTH_LP)
  ) u_align (
    .head_ent (head_ent),
    .next_ent (next_ent),
    .half     (half),
    .insn     (out_insn_o),
    .rvc      (out_rvc_o),
    .vld      (out_vld_o),
    .fault    (out_fault_o),
    .pc       (out_pc_o),
    .tid      (out_tid_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH_P; i++) mem_reg[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH_P; i++) mem_reg[i].vld <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH_P; i++) begin
        if (push && wr_ptr_reg == PTR_WIDTH_LP'(i))      mem_reg[i] <= wr_ent;
        else if (free && rd_ptr_reg == PTR_WIDTH_LP'(i)) mem_reg[i].vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      half_set_reg <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      half_set_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (free) rd_ptr_reg <= rd_ptr_inc;
      count_reg    <= count_reg + CNT_WIDTH_LP'(push) - CNT_WIDTH_LP'(free);
      half_set_reg <= half_set_next;
    end
  end

endmodule

// File: tb/tb_mrv1_ifq.sv
// Self-checking bench for mrv1_ifq (DEPTH_P=3): queue-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mrv1_ifq;

  localparam int DEPTH = 3;

  logic        clk, rst_n, flush;
  logic        in_vld, in_rdy, out_vld, out_rdy;
  logic [31:0] in_data, in_pc, out_insn, out_pc;
  logic [2:0]  in_tid, out_tid;
  logic        out_rvc, out_fault, empty, full;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  mrv1_ifq #(.PC_WIDTH_P(32), .NUM_THREADS_P(8), .DEPTH_P(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_data_i(in_data), .in_pc_i(in_pc), .in_tid_i(in_tid),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_insn_o(out_insn), .out_pc_o(out_pc),
    .out_tid_o(out_tid), .out_rvc_o(out_rvc), .out_fault_o(out_fault),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: a queue of fetch words plus "lower parcel of head already consumed".
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic [2:0]  tid;
  } word_t;

  word_t q[$];
  bit    m_skip;
  bit    m_pushed;

  function automatic void model_out(output bit v, output logic [31:0] insn, output logic [31:0] pc,
                                    output logic [2:0] tid, output bit rvc, output bit fault,
                                    output bit h);
    logic [15:0] parcel;
    v = 0; insn = 0; pc = 0; tid = 0; rvc = 0; fault = 0; h = 0;
    if (q.size() == 0) return;
    h      = m_skip || q[0].pc[1];
    parcel = h ? q[0].data[31:16] : q[0].data[15:0];
    pc     = {q[0].pc[31:2], h, 1'b0};
    tid    = q[0].tid;
    if (parcel[1:0] != 2'b11) begin
      v = 1; rvc = 1; insn = {16'h0, parcel};
    end else if (!h) begin
      v = 1; insn = q[0].data;
    end else if (q.size() >= 2) begin
      v     = 1;
      insn  = {q[1].data[15:0], q[0].data[31:16]};
      fault = !((q[1].tid == q[0].tid) && (q[1].pc[31:2] == q[0].pc[31:2] + 30'd1));
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit mv, mrvc, mfault, mh, do_pop, do_push;
    logic [31:0] minsn, mpc;
    logic [2:0]  mtid;
    if (!rst_n) begin
      q.delete();
      m_skip   = 0;
      m_pushed = 0;
    end else begin
      m_pushed = 0;
      if (flush) begin
        q.delete();
        m_skip = 0;
      end else begin
        model_out(mv, minsn, mpc, mtid, mrvc, mfault, mh);
        do_pop  = mv && out_rdy;
        do_push = in_vld && (q.size() < DEPTH);
        if (do_pop) begin
          $display("pop  pc=%h insn=%h tid=%0d rvc=%0d fault=%0d", mpc, minsn, mtid, mrvc, mfault);
          if (mrvc && !mh) m_skip = 1;
          else begin
            void'(q.pop_front());
            m_skip = !mrvc && mh && !mfault;
          end
        end
        if (do_push) begin
          $display("push pc=%h data=%h tid=%0d", in_pc, in_data, in_tid);
          q.push_back('{data: in_data, pc: in_pc, tid: in_tid});
          m_pushed = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit mv, mrvc, mfault, mh;
    logic [31:0] minsn, mpc;
    logic [2:0]  mtid;
    model_out(mv, minsn, mpc, mtid, mrvc, mfault, mh);
    chk("m_out_vld", out_vld, mv);
    chk("m_count", count, 32'(q.size()));
    chk("m_in_rdy", in_rdy, q.size() < DEPTH);
    chk("m_empty", empty, q.size() == 0);
    chk("m_full", full, q.size() == DEPTH);
    if (mv) begin
      chk("m_insn", out_insn, minsn);
      chk("m_pc", out_pc, mpc);
      chk("m_tid", out_tid, mtid);
      chk("m_rvc", out_rvc, mrvc);
      chk("m_fault", out_fault, mfault);
    end
  end

  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] pc,
                      input logic [2:0] t, input bit rdy, input bit fl = 0);
    in_vld = v; in_data = d; in_pc = pc; in_tid = t; out_rdy = rdy; flush = fl;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 1);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_fault"}, out_fault, 0);
    chk({tag, "_rvc"}, out_rvc, 0);
    chk({tag, "_insn"}, out_insn, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_tid"}, out_tid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
  endtask

  initial begin
    logic [31:0] next_pc, exp_pop;
    rst_n = 0; flush = 0; in_vld = 0; in_data = 0; in_pc = 0; in_tid = 0; out_rdy = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;

    // single 32-bit word
    step(1, 32'h0000_0013, 32'h100, 3'd2, 0);
    chk("w32_vld", out_vld, 1); chk("w32_insn", out_insn, 32'h13);
    chk("w32_pc", out_pc, 32'h100); chk("w32_rvc", out_rvc, 0); chk("w32_tid", out_tid, 2);
    step(0, 0, 0, 0, 1);
    chk("w32_empty", empty, 1);

    // two RVC in one word
    step(1, 32'h4501_4505, 32'h200, 3'd1, 0);
    chk("rvc0_insn", out_insn, 32'h4505); chk("rvc0_pc", out_pc, 32'h200);
    chk("rvc0_rvc", out_rvc, 1); chk("rvc0_count", count, 1);
    step(0, 0, 0, 0, 1);
    chk("rvc1_insn", out_insn, 32'h4501); chk("rvc1_pc", out_pc, 32'h202);
    chk("rvc1_rvc", out_rvc, 1); chk("rvc1_count", count, 1);
    step(0, 0, 0, 0, 1);
    chk("rvc_drained", count, 0);

    // contiguous spanning instruction
    step(1, 32'h0013_4505, 32'h300, 3'd3, 0);
    step(1, 32'h1234_0000, 32'h304, 3'd3, 0);
    chk("sp_rvc_insn", out_insn, 32'h4505); chk("sp_rvc_pc", out_pc, 32'h300); chk("sp_count", count, 2);
    step(0, 0, 0, 0, 1);
    chk("sp_insn", out_insn, 32'h0000_0013); chk("sp_pc", out_pc, 32'h302);
    chk("sp_rvc", out_rvc, 0); chk("sp_fault", out_fault, 0);
    step(0, 0, 0, 0, 1);
    chk("sp_next_pc", out_pc, 32'h306); chk("sp_next_insn", out_insn, 32'h1234);
    chk("sp_next_count", count, 1);
    step(0, 0, 0, 0, 1);
    chk("sp_empty", empty, 1);

    // spanning across a thread change: faulted
    step(1, 32'h0013_4505, 32'h400, 3'd3, 0);
    step(1, 32'h1234_0000, 32'h404, 3'd4, 0);
    step(0, 0, 0, 0, 1);
    chk("ft_fault", out_fault, 1); chk("ft_vld", out_vld, 1);
    chk("ft_pc", out_pc, 32'h402); chk("ft_insn", out_insn, 32'h13);
    step(0, 0, 0, 0, 1);
    chk("ft_next_pc", out_pc, 32'h404); chk("ft_next_insn", out_insn, 32'h0);
    chk("ft_next_fault", out_fault, 0); chk("ft_next_tid", out_tid, 4);
    step(0, 0, 0, 0, 1);
    chk("ft_hi_pc", out_pc, 32'h406);
    step(0, 0, 0, 0, 1);
    chk("ft_empty", empty, 1);

    // fill to full, then stream with wrap
    step(1, 32'h13, 32'h500, 3'd1, 0);
    step(1, 32'h13, 32'h504, 3'd1, 0);
    step(1, 32'h13, 32'h508, 3'd1, 0);
    step(1, 32'h13, 32'h50C, 3'd1, 0);
    chk("full_flag", full, 1); chk("full_rdy", in_rdy, 0); chk("full_count", count, 3);
    next_pc = 32'h50C;
    exp_pop = 32'h500;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_vld", out_vld, 1);
      chk("wrap_pc", out_pc, exp_pop);
      step(1, 32'h13, next_pc, 3'd1, 1);
      exp_pop = exp_pop + 32'd4;
      if (m_pushed) next_pc = next_pc + 32'd4;
    end
    repeat (3) step(0, 0, 0, 0, 1);
    chk("wrap_empty", empty, 1);

    // flush with a concurrent enqueue
    step(1, 32'h13, 32'h600, 3'd0, 0);
    step(1, 32'h13, 32'h604, 3'd0, 0);
    chk("pre_flush_count", count, 2);
    step(1, 32'h13, 32'h608, 3'd0, 0, 1);
    chk("flush_count", count, 0); chk("flush_vld", out_vld, 0);
    chk("flush_rdy", in_rdy, 1); chk("flush_empty", empty, 1);

    // asynchronous reset mid-stream
    step(1, 32'h13, 32'h700, 3'd5, 0);
    step(1, 32'h13, 32'h704, 3'd5, 0);
    chk("pre_rst_count", count, 2);
    #2 rst_n = 0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1;
    step(1, 32'h0000_0013, 32'h800, 3'd6, 0);
    chk("post_rst_pc", out_pc, 32'h800); chk("post_rst_tid", out_tid, 6);
    step(0, 0, 0, 0, 1);
    chk("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
